// File: rtl/swivm_bus_responder_if.sv
// swivm_bus_responder_if: req/ack CPU bus between the swivm CPU (master) and a memory responder (slave)
interface swivm_bus_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  modport master (output req, we, addr, wdata, input ack, rdata, busy);
  modport slave (input req, we, addr, wdata, output ack, rdata, busy);
endinterface

// File: rtl/swivm_bus_responder.sv
// swivm_bus_responder: single-transaction word-RAM target with fixed wait states and optional console byte port
// Define SWIVM_CONSOLE_EN to turn CONSOLE_ADDR into a write-only console register.
module swivm_bus_responder #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] CONSOLE_ADDR = ADDR_W'('h3FF)
) (
  input  logic                 clk,
  input  logic                 reset,
  swivm_bus_responder_if.slave bus,
  output logic                 con_valid,
  output logic [7:0]           con_data
);
  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;
  localparam logic [7:0] WAIT_INIT = 8'(WAIT_CYCLES);
`ifdef SWIVM_CONSOLE_EN
  localparam bit CON_EN = 1'b1;
`else
  localparam bit CON_EN = 1'b0;
`endif
  state_t            state, state_n;
  logic [7:0]        cnt, cnt_n;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic              commit;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              hit_con;
  // With zero wait states the commit happens on the accepting edge, so use the live bus fields there.
  assign c_we    = state == IDLE ? bus.we : we_q;
  assign c_addr  = state == IDLE ? bus.addr : addr_q;
  assign c_wdata = state == IDLE ? bus.wdata : wdata_q;
  assign hit_con = CON_EN && c_addr == CONSOLE_ADDR;
  assign bus.ack   = state == ACK;
  assign bus.busy  = state != IDLE;
  assign bus.rdata = rdata_q;
  // Next state, wait counter and the commit strobe marking the edge that enters ACK.
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    commit = 1'b0;
    case (state)
      IDLE: if (bus.req) begin
        cnt_n = WAIT_INIT;
        commit = WAIT_INIT == 8'd0;
        state_n = commit ? ACK : WAIT;
      end
      WAIT: begin
        cnt_n = cnt - 8'd1;
        commit = cnt == 8'd1;
        state_n = commit ? ACK : WAIT;
      end
      default: state_n = IDLE;
    endcase
  end
  // State register and request capture at acceptance.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 8'd0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (state == IDLE && bus.req) begin
        we_q <= bus.we;
        addr_q <= bus.addr;
        wdata_q <= bus.wdata;
      end
    end
  end
  // Word RAM, not reset; a write in flight when reset hits is dropped.
  always_ff @(posedge clk) begin
    if (!reset && commit && c_we && !hit_con) mem[c_addr] <= c_wdata;
  end
  // Read data register, held between reads.
  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else if (commit && !c_we) rdata_q <= hit_con ? '0 : mem[c_addr];
  end
`ifdef SWIVM_CONSOLE_EN
  logic       con_valid_q;
  logic [7:0] con_data_q;
  // Console byte emitted alongside the ack of a write to CONSOLE_ADDR.
  always_ff @(posedge clk) begin
    if (reset) begin
      con_valid_q <= 1'b0;
      con_data_q <= 8'd0;
    end else begin
      con_valid_q <= commit && c_we && hit_con;
      if (commit && c_we && hit_con) con_data_q <= c_wdata[7:0];
    end
  end
  assign con_valid = con_valid_q;
  assign con_data = con_data_q;
`else
  assign con_valid = 1'b0;
  assign con_data = 8'd0;
`endif
endmodule

// File: tb/tb_swivm_bus_responder.sv
// tb_swivm_bus_responder: directed checks of two responders (2 and 0 wait states)
module tb_swivm_bus_responder;
`ifdef SWIVM_CONSOLE_EN
  localparam bit CON = 1'b1;
`else
  localparam bit CON = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset;
  logic req, we, sel;
  logic [9:0] addr;
  logic [31:0] wdata;
  logic a_cv, b_cv;
  logic [7:0] a_cd, b_cd;
  logic ack, busy, cv;
  logic [31:0] rdata;
  logic [7:0] cd;
  int n_tests = 0;
  int n_fail = 0;
  int lat, bsy, cvn, n, prev, idle_cnt;
  logic [31:0] rd;
  logic [7:0] cd_cap;
  swivm_bus_responder_if a_if();
  swivm_bus_responder_if b_if();
  swivm_bus_responder #(.WAIT_CYCLES(2)) u_a (.clk(clk), .reset(reset), .bus(a_if.slave), .con_valid(a_cv), .con_data(a_cd));
  swivm_bus_responder #(.WAIT_CYCLES(0)) u_b (.clk(clk), .reset(reset), .bus(b_if.slave), .con_valid(b_cv), .con_data(b_cd));
  assign a_if.req = req & ~sel;
  assign b_if.req = req & sel;
  assign a_if.we = we;
  assign b_if.we = we;
  assign a_if.addr = addr;
  assign b_if.addr = addr;
  assign a_if.wdata = wdata;
  assign b_if.wdata = wdata;
  assign ack = sel ? b_if.ack : a_if.ack;
  assign busy = sel ? b_if.busy : a_if.busy;
  assign rdata = sel ? b_if.rdata : a_if.rdata;
  assign cv = sel ? b_cv : a_cv;
  assign cd = sel ? b_cd : a_cd;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // One transaction: lat counts edges from acceptance to the first ack sample; bsy and cvn count sampled cycles.
  task automatic xact(input logic w, input logic [9:0] a, input logic [31:0] d, input bit scramble);
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
    bsy = 0;
    cvn = 0;
    @(posedge clk); #1;
    lat = 1;
    bsy += int'(busy);
    cvn += int'(cv);
    if (scramble) begin
      req = 1'b0;
      we = ~w;
      addr = a ^ 10'h001;
      wdata = ~d;
    end
    while (!ack && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      bsy += int'(busy);
      cvn += int'(cv);
    end
    rd = rdata;
    cd_cap = cd;
    req = 1'b0;
    @(posedge clk); #1;
    bsy += int'(busy);
    cvn += int'(cv);
  endtask
  initial begin
    reset = 1'b1;
    req = 1'b0;
    we = 1'b0;
    sel = 1'b0;
    addr = '0;
    wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_a_ack", {31'd0, a_if.ack}, 32'd0);
    chk("rst_a_busy", {31'd0, a_if.busy}, 32'd0);
    chk("rst_a_rdata", a_if.rdata, 32'd0);
    chk("rst_b_busy", {31'd0, b_if.busy}, 32'd0);
    chk("rst_con", {23'd0, a_cv, a_cd}, 32'd0);
    xact(1'b1, 10'h010, 32'hDEADBEEF, 1'b0);
    chk("t1_wr_lat", 32'(lat), 32'd3);
    chk("t1_wr_busy", 32'(bsy), 32'd3);
    xact(1'b0, 10'h010, 32'h0, 1'b0);
    chk("t1_rd_lat", 32'(lat), 32'd3);
    chk("t1_rd_data", rd, 32'hDEADBEEF);
    chk("t1_rd_held", rdata, 32'hDEADBEEF);
    sel = 1'b1;
    xact(1'b1, 10'h001, 32'h5, 1'b0);
    chk("t2_wr_lat", 32'(lat), 32'd1);
    chk("t2_wr_busy", 32'(bsy), 32'd1);
    xact(1'b0, 10'h001, 32'h0, 1'b0);
    chk("t2_rd_lat", 32'(lat), 32'd1);
    chk("t2_rd_busy", 32'(bsy), 32'd1);
    chk("t2_rd_data", rd, 32'h5);
    sel = 1'b0;
    for (int i = 0; i < 3; i++) xact(1'b1, 10'(i), 32'h100 + 32'(i), 1'b0);
    req = 1'b1;
    we = 1'b0;
    addr = 10'h000;
    n = 0;
    prev = 0;
    idle_cnt = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      @(posedge clk); #1;
      if (!busy) idle_cnt++;
      if (ack) begin
        chk("t3_rdata", rdata, 32'h100 + 32'(n));
        if (n > 0) chk("t3_gap", 32'(c - prev), 32'd4);
        prev = c;
        n++;
        addr = 10'(n);
      end
    end
    req = 1'b0;
    chk("t3_acks", 32'(n), 32'd3);
    chk("t3_idle", 32'(idle_cnt), 32'd2);
    @(posedge clk); #1;
    xact(1'b1, 10'h031, 32'h55, 1'b0);
    xact(1'b1, 10'h030, 32'hAA, 1'b1);
    chk("t6_ack_after_drop", 32'(lat), 32'd3);
    chk("t6_rdata_held", rd, 32'h102);
    xact(1'b0, 10'h030, 32'h0, 1'b0);
    chk("t6_rd_030", rd, 32'hAA);
    xact(1'b0, 10'h031, 32'h0, 1'b0);
    chk("t6_rd_031", rd, 32'h55);
    xact(1'b1, 10'h020, 32'h77, 1'b0);
    req = 1'b1;
    we = 1'b1;
    addr = 10'h020;
    wdata = 32'h1234;
    @(posedge clk); #1;
    chk("t4_busy_wait", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    req = 1'b0;
    @(posedge clk); #1;
    chk("t4_ack", {31'd0, ack}, 32'd0);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_rdata", rdata, 32'd0);
    chk("t4_con", {23'd0, cv, cd}, 32'd0);
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("t4_no_ack", {31'd0, ack}, 32'd0);
    end
    xact(1'b0, 10'h020, 32'h0, 1'b0);
    chk("t4_rd_020", rd, 32'h77);
    xact(1'b1, 10'h3FF, 32'h00000041, 1'b0);
    chk("t5_con_valid_n", 32'(cvn), CON ? 32'd1 : 32'd0);
    chk("t5_con_data", {24'd0, cd_cap}, CON ? 32'h41 : 32'h0);
    xact(1'b0, 10'h3FF, 32'h0, 1'b0);
    chk("t5_rd_con", rd, CON ? 32'h0 : 32'h41);
    reset = 1'b1;
    req = 1'b1;
    we = 1'b0;
    addr = 10'h000;
    @(posedge clk); #1;
    reset = 1'b0;
    req = 1'b0;
    @(posedge clk); #1;
    chk("rst_req_busy", {31'd0, busy}, 32'd0);
    chk("rst_req_ack", {31'd0, ack}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
